a78_loader: RTL and testbench

A78_LOADER -- requirements
Module: a78_loader

---
 rtl/a78_pkg.sv | 29 ++
 rtl/a78_hdr_buf.sv | 22 ++
 rtl/a78_loader.sv | 183 ++++++++++++++++++
 tb/tb_a78_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a78_pkg.sv
// Shared A78 loader definitions: FSM states, header geometry, magic string and field offsets.
package a78_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StReplay,
    StStream,
    StFinish
  } a78_state_e;

  localparam int unsigned HDR_LEN    = 128;
  localparam int unsigned MAGIC_OFF  = 1;
  localparam int unsigned MAGIC_LEN  = 9;
  localparam logic [71:0] MAGIC      = "ATARI7800";
  localparam int unsigned SIZE_OFF   = 49;
  localparam int unsigned TYPE_OFF   = 53;
  localparam int unsigned TYPE2_OFF  = 54;
  localparam int unsigned REGION_OFF = 57;

  // Character k (0-based) of the magic string; 0 outside the string.
  function automatic logic [7:0] magic_byte(input int unsigned i);
    magic_byte = 8'h00;
    for (int unsigned k = 0; k < MAGIC_LEN; k++) begin
      if (k == i) magic_byte = MAGIC[8*(MAGIC_LEN-1-k) +: 8];
    end
  endfunction

endpackage

// File: rtl/a78_hdr_buf.sv
// Header capture buffer: one write port, one synchronous read port.
module a78_hdr_buf #(
  parameter int unsigned Depth = 128,
  parameter int unsigned Aw    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [Aw-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [Aw-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/a78_loader.sv
// A78 cart loader: strips/decodes a 128-byte header or replays it as ROM data,
// then streams the download into cart ROM.
module a78_loader #(
  parameter int unsigned HDR_LEN = a78_pkg::HDR_LEN,
  parameter int unsigned ROM_AW  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_en,
  input  logic              dl_wr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic              loading,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [9:0]        cart_flags,
  output logic [31:0]       cart_size,
  output logic              cart_region,
  output logic              hdr_valid,
  output logic              overflow
);
  import a78_pkg::*;

  localparam int unsigned CW  = $clog2(HDR_LEN + 1);
  localparam int unsigned BAW = $clog2(HDR_LEN);

  a78_state_e      state_q;
  logic            dl_en_q;
  logic            en_rise, en_fall;
  logic [CW-1:0]   cnt_q, idx_q;
  logic            not_hdr_q, tail_q, pend_q;
  logic [31:0]     size_q;
  logic [9:0]      flags_q;
  logic            region_q;
  logic [ROM_AW:0] wa_q;  // extra MSB marks the saturated end of ROM
  logic            buf_we, rd_en, wr_go, magic_bad;
  logic [7:0]      rd_data, wr_byte;

  assign en_rise = dl_en & ~dl_en_q;
  assign en_fall = ~dl_en & dl_en_q;

  always_comb begin
    buf_we    = (state_q == StHdr) && dl_wr && !en_rise && !en_fall;
    rd_en     = (state_q == StReplay) && (idx_q < cnt_q);
    wr_go     = !en_rise && (((state_q == StReplay) && pend_q) ||
                             ((state_q == StStream) && dl_wr));
    wr_byte   = (state_q == StReplay) ? rd_data : dl_data;
    magic_bad = (cnt_q >= CW'(MAGIC_OFF)) && (cnt_q < CW'(MAGIC_OFF + MAGIC_LEN)) &&
                (dl_data != magic_byte(32'(cnt_q) - MAGIC_OFF));
  end

  a78_hdr_buf #(
    .Depth (HDR_LEN),
    .Aw    (BAW)
  ) u_hdr_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[BAW-1:0]),
    .wdata (dl_data),
    .re    (rd_en),
    .raddr (idx_q[BAW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_en_q     <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      not_hdr_q   <= 1'b0;
      tail_q      <= 1'b0;
      pend_q      <= 1'b0;
      size_q      <= '0;
      flags_q     <= '0;
      region_q    <= 1'b0;
      wa_q        <= '0;
      loading     <= 1'b0;
      dl_wait     <= 1'b0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_data    <= '0;
      cart_flags  <= '0;
      cart_size   <= '0;
      cart_region <= 1'b0;
      hdr_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dl_en_q <= dl_en;
      rom_we  <= 1'b0;
      pend_q  <= 1'b0;
      if (en_rise) begin
        state_q     <= StHdr;
        cnt_q       <= '0;
        idx_q       <= '0;
        not_hdr_q   <= 1'b0;
        tail_q      <= 1'b0;
        wa_q        <= '0;
        loading     <= 1'b1;
        dl_wait     <= 1'b0;
        hdr_valid   <= 1'b0;
        overflow    <= 1'b0;
        cart_flags  <= '0;
        cart_size   <= '0;
        cart_region <= 1'b0;
      end else begin
        case (state_q)
          StHdr: begin
            if (en_fall) begin
              // Short file: replay whatever arrived, then finish.
              idx_q  <= '0;
              tail_q <= 1'b1;
              if (cnt_q == '0) begin
                state_q <= StFinish;
              end else begin
                state_q <= StReplay;
                dl_wait <= 1'b1;
              end
            end else if (dl_wr) begin
              cnt_q <= cnt_q + 1'b1;
              if (magic_bad) not_hdr_q <= 1'b1;
              if ((cnt_q >= CW'(SIZE_OFF)) && (cnt_q < CW'(SIZE_OFF + 4))) begin
                size_q <= {size_q[23:0], dl_data};
              end
              if (cnt_q == CW'(TYPE_OFF))   flags_q[9:8] <= dl_data[1:0];
              if (cnt_q == CW'(TYPE2_OFF))  flags_q[7:0] <= dl_data;
              if (cnt_q == CW'(REGION_OFF)) region_q     <= dl_data[0];
              if (cnt_q == CW'(HDR_LEN - 1)) begin
                idx_q <= '0;
                if (!not_hdr_q && !magic_bad) begin
                  cart_size   <= size_q;
                  cart_flags  <= flags_q;
                  cart_region <= region_q;
                  hdr_valid   <= 1'b1;
                  state_q     <= StStream;
                end else begin
                  tail_q  <= 1'b0;
                  state_q <= StReplay;
                  dl_wait <= 1'b1;
                end
              end
            end
          end
          StReplay: begin
            if (en_fall) tail_q <= 1'b1;
            if (idx_q < cnt_q) begin
              idx_q  <= idx_q + 1'b1;
              pend_q <= 1'b1;
            end else if (pend_q) begin
              // Last buffered byte is written on this edge; dl_wait clears in the next state.
              state_q <= (tail_q || en_fall) ? StFinish : StStream;
            end
          end
          StStream: begin
            dl_wait <= 1'b0;
            if (en_fall) state_q <= StFinish;
          end
          StFinish: begin
            loading <= 1'b0;
            dl_wait <= 1'b0;
            state_q <= StIdle;
          end
          StIdle: ;
          default: state_q <= StIdle;
        endcase

        if (wr_go) begin
          if (!wa_q[ROM_AW]) begin
            rom_we   <= 1'b1;
            rom_addr <= wa_q[ROM_AW-1:0];
            rom_data <= wr_byte;
            wa_q     <= wa_q + 1'b1;
            if (!hdr_valid) cart_size <= 32'(wa_q) + 32'd1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_a78_loader.sv
// Scoreboard bench for a78_loader: directed downloads, expected ROM writes queued at stimulus time.
module tb_a78_loader;
  localparam int unsigned HDR_LEN = 128;
  localparam int unsigned ROM_AW  = 15;  // 32 KiB ROM keeps the overflow case short

  logic              clk = 1'b0;
  logic              reset, dl_en, dl_wr;
  logic [7:0]        dl_data;
  logic              dl_wait, loading, rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [9:0]        cart_flags;
  logic [31:0]       cart_size;
  logic              cart_region, hdr_valid, overflow;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [7:0]        data;
    logic              wt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  a78_loader #(
    .HDR_LEN (HDR_LEN),
    .ROM_AW  (ROM_AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dl_en       (dl_en),
    .dl_wr       (dl_wr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .loading     (loading),
    .rom_we      (rom_we),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .cart_flags  (cart_flags),
    .cart_size   (cart_size),
    .cart_region (cart_region),
    .hdr_valid   (hdr_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0 && rom_we === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rom_we_unexpected: got addr=%h data=%h, required no write", rom_addr,
                 rom_data);
      end else begin
        e = sb.pop_front();
        if (rom_addr !== e.addr || rom_data !== e.data || dl_wait !== e.wt) begin
          n_fail++;
          $display("FAIL rom_write: got addr=%h data=%h wait=%b, required addr=%h data=%h wait=%b",
                   rom_addr, rom_data, dl_wait, e.addr, e.data, e.wt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [7:0] seed);
    return 8'(i ^ (i >> 8)) ^ seed;
  endfunction

  function automatic logic [7:0] magic_at(input int i);
    logic [71:0] m;
    m = "ATARI7800";
    return m[8*(9-i) +: 8];
  endfunction

  function automatic logic [7:0] hdr_byte(input int i);
    case (i)
      0:       return 8'h01;
      49, 50:  return 8'h00;
      51:      return 8'hC0;
      52:      return 8'h00;
      53:      return 8'h01;
      54:      return 8'h02;
      57:      return 8'h01;
      default: return (i >= 1 && i <= 9) ? magic_at(i) : pat(i, 8'h11);
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (dl_wait === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (dl_wait !== 1'b0) chk("dl_wait_timeout", 32'(dl_wait), 32'd0);
    dl_data = b;
    dl_wr   = 1'b1;
    @(posedge clk); #1;
    dl_wr   = 1'b0;
  endtask

  task automatic start_load();
    dl_en = 1'b1;
    @(posedge clk); #1;
    chk("loading_on_start", 32'(loading), 32'd1);
  endtask

  task automatic end_load();
    int n = 0;
    dl_en = 1'b0;
    @(posedge clk); #1;
    while (loading === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("loading_dropped", 32'(loading), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("all_writes_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic push_exp(input int a, input logic [7:0] d, input logic wt);
    exp_t e;
    e.addr = ROM_AW'(a);
    e.data = d;
    e.wt   = wt;
    sb.push_back(e);
  endtask

  task automatic load_header(input int n_data, input bit finish);
    logic [7:0] b;
    start_load();
    for (int i = 0; i < HDR_LEN; i++) send_byte(hdr_byte(i));
    chk("hdr_valid", 32'(hdr_valid), 32'd1);
    chk("hdr_cart_size", cart_size, 32'h0000C000);
    chk("hdr_cart_flags", 32'(cart_flags), 32'h102);
    chk("hdr_cart_region", 32'(cart_region), 32'd1);
    chk("hdr_dl_wait", 32'(dl_wait), 32'd0);
    for (int j = 0; j < n_data; j++) begin
      b = pat(j, 8'hC3);
      push_exp(j, b, 1'b0);
      send_byte(b);
    end
    if (finish) begin
      end_load();
      chk("hdr_valid_end", 32'(hdr_valid), 32'd1);
      chk("hdr_size_end", cart_size, 32'h0000C000);
      chk("hdr_overflow", 32'(overflow), 32'd0);
    end
  endtask

  task automatic load_raw(input int n, input logic [7:0] seed, input bit inject, input bit xatari);
    logic [7:0] b;
    start_load();
    for (int i = 0; i < n; i++) begin
      if (xatari && i == 0)                b = "x";
      else if (xatari && i >= 1 && i <= 9) b = magic_at(i);
      else                                 b = pat(i, seed);
      if (i < (1 << ROM_AW)) push_exp(i, b, i < HDR_LEN);
      send_byte(b);
      if (inject && i == HDR_LEN - 1) begin
        chk("replay_dl_wait", 32'(dl_wait), 32'd1);
        for (int k = 0; k < 4; k++) begin
          dl_data = 8'hFF;
          dl_wr   = 1'b1;
          @(posedge clk); #1;
          dl_wr   = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    end_load();
    chk("raw_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("raw_cart_flags", 32'(cart_flags), 32'd0);
    chk("raw_cart_region", 32'(cart_region), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_dl_wait", 32'(dl_wait), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_data", 32'(rom_data), 32'd0);
    chk("rst_cart_flags", 32'(cart_flags), 32'd0);
    chk("rst_cart_size", cart_size, 32'd0);
    chk("rst_cart_region", 32'(cart_region), 32'd0);
    chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    dl_en   = 1'b0;
    dl_wr   = 1'b0;
    dl_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // Valid header, then reset while still streaming.
    load_header(64, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midstream_loading", 32'(loading), 32'd1);
    chk("midstream_writes_seen", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    dl_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean header load after the abandoned one.
    load_header(300, 1'b1);

    // Headerless 32 KiB with dl_wr pulses injected during replay.
    load_raw(32768, 8'h5A, 1'b1, 1'b0);
    chk("raw32k_size", cart_size, 32'h00008000);
    chk("raw32k_overflow", 32'(overflow), 32'd0);

    // Short file that carries the magic but ends before a full header.
    load_raw(40, 8'h77, 1'b0, 1'b1);
    chk("short_size", cart_size, 32'd40);
    chk("short_overflow", 32'(overflow), 32'd0);

    // Larger than the ROM: tail is dropped, address saturates.
    load_raw(32768 + 256, 8'h3C, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_size", cart_size, 32'h00008000);
    chk("ovf_last_addr", 32'(rom_addr), 32'h00007FFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
